// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the scoreboarded register file.
// The byte merge is written at a fixed maximum width; callers zero-extend and truncate.
package reg_file_pkg;

  typedef enum logic {SCRUB, READY} rf_state_e;

  localparam int RF_MAX_W  = 256;
  localparam int RF_MAX_BE = RF_MAX_W / 8;

  function automatic logic [RF_MAX_W-1:0] byte_merge(
    input logic [RF_MAX_W-1:0]  old_v,
    input logic [RF_MAX_W-1:0]  new_v,
    input logic [RF_MAX_BE-1:0] be
  );
    logic [RF_MAX_W-1:0] merged;
    merged = old_v;
    for (int b = 0; b < RF_MAX_BE; b++) begin
      if (be[b]) merged[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy flags: set/clear take effect at the edge, lookups are combinational.
// No backpressure; flush wins over set, set wins over clear to the same entry.
module rf_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] lk1_addr_i,
  input  logic [ADDR_W-1:0] lk2_addr_i,
  output logic              lk1_busy_o,
  output logic              lk2_busy_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_i)   busy_d[clr_addr_i] = 1'b0;
    if (set_i)   busy_d[set_addr_i] = 1'b1;
    if (flush_i) busy_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign lk1_busy_o = (32'(lk1_addr_i) < 32'(NUM_REGS)) ? busy_q[lk1_addr_i] : 1'b0;
  assign lk2_busy_o = (32'(lk2_addr_i) < 32'(NUM_REGS)) ? busy_q[lk2_addr_i] : 1'b0;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with 2 combinational read ports, 1 byte-enabled write port and busy scoreboard.
// Writes land at the edge (optionally forwarded same cycle); ready_o low while the scrub FSM zeroes the array.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  output logic                 ready_o,
  input  logic                 rd_wren_i,
  input  logic [ADDR_W-1:0]    rd_addr_i,
  input  logic [DATA_W/8-1:0]  rd_be_i,
  input  logic [DATA_W-1:0]    rd_data_i,
  input  logic                 sb_set_i,
  input  logic [ADDR_W-1:0]    sb_addr_i,
  input  logic [ADDR_W-1:0]    rs1_addr_i,
  input  logic [ADDR_W-1:0]    rs2_addr_i,
  output logic [DATA_W-1:0]    rs1_data_o,
  output logic [DATA_W-1:0]    rs2_data_o,
  output logic                 rs1_busy_o,
  output logic                 rs2_busy_o
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);

  rf_state_e         state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic              ready;
  logic              wr_ok;
  logic              sb_ok;
  logic              flush;
  logic [DATA_W-1:0] wr_merged;
  logic [ADDR_W-1:0] rs_addr [2];
  logic              rs_ok   [2];
  logic              lk_busy [2];
  logic [DATA_W-1:0] rs_data [2];
  logic              rs_busy [2];

  // Addresses past the array end and the hardwired zero register never hold state.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(NUM_REGS)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign ready   = (state_q == READY);
  assign ready_o = ready;

  assign wr_ok = ready && !clear_i && rd_wren_i && addr_ok(rd_addr_i);
  assign sb_ok = ready && !clear_i && sb_set_i  && addr_ok(sb_addr_i);
  assign flush = ready && clear_i;

  assign wr_merged = DATA_W'(byte_merge(RF_MAX_W'(regs_q[rd_addr_i]),
                                        RF_MAX_W'(rd_data_i),
                                        RF_MAX_BE'(rd_be_i)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SCRUB;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        SCRUB: begin
          if (ptr_q == LAST_PTR) begin
            state_q <= READY;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        READY: begin
          if (clear_i) begin
            state_q <= SCRUB;
            ptr_q   <= '0;
          end
        end
        default: begin
          state_q <= SCRUB;
          ptr_q   <= '0;
        end
      endcase
    end
  end

  // The array carries no reset; the scrub walk is what zeroes it.
  always_ff @(posedge clk_i) begin
    if (!ready)     regs_q[ptr_q]     <= '0;
    else if (wr_ok) regs_q[rd_addr_i] <= wr_merged;
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_sb (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush),
    .set_i      (sb_ok),
    .set_addr_i (sb_addr_i),
    .clr_i      (wr_ok),
    .clr_addr_i (rd_addr_i),
    .lk1_addr_i (rs1_addr_i),
    .lk2_addr_i (rs2_addr_i),
    .lk1_busy_o (lk_busy[0]),
    .lk2_busy_o (lk_busy[1])
  );

  assign rs_addr[0] = rs1_addr_i;
  assign rs_addr[1] = rs2_addr_i;
  assign rs_ok[0]   = addr_ok(rs1_addr_i);
  assign rs_ok[1]   = addr_ok(rs2_addr_i);

  // A forwarded write also reports the post-edge busy state of that register.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rs_data[p] = '0;
      rs_busy[p] = 1'b0;
      if (ready && rs_ok[p]) begin
        rs_data[p] = regs_q[rs_addr[p]];
        rs_busy[p] = lk_busy[p];
        if ((BYPASS != 0) && wr_ok && (rd_addr_i == rs_addr[p])) begin
          rs_data[p] = wr_merged;
          rs_busy[p] = sb_ok && (sb_addr_i == rs_addr[p]);
        end
      end
    end
  end

  assign rs1_data_o = rs_data[0];
  assign rs2_data_o = rs_data[1];
  assign rs1_busy_o = rs_busy[0];
  assign rs2_busy_o = rs_busy[1];

endmodule

// File: tb/tb_reg_file_sb.sv
// Drives two configurations from shared stimulus: A (32b, 8 regs, bypass) and B (8b, 6 regs, zero reg, no bypass).
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear, wren, sb_set;
  logic [2:0]  wa, sa, r1, r2;
  logic [3:0]  be;
  logic [31:0] wd;

  logic        ready_a, busy1_a, busy2_a;
  logic [31:0] rs1_a, rs2_a;
  logic        ready_b, busy1_b, busy2_b;
  logic [7:0]  rs1_b, rs2_b;

  int checks = 0;
  int errors = 0;

  // Reference state: register contents, busy flags, remaining scrub cycles.
  logic [31:0] ma [8];
  bit          mab [8];
  int          ma_scrub;
  logic [7:0]  mb [6];
  bit          mbb [6];
  int          mb_scrub;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(32), .NUM_REGS(8), .ZERO_REG(0), .BYPASS(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .ready_o(ready_a),
    .rd_wren_i(wren), .rd_addr_i(wa), .rd_be_i(be), .rd_data_i(wd),
    .sb_set_i(sb_set), .sb_addr_i(sa), .rs1_addr_i(r1), .rs2_addr_i(r2),
    .rs1_data_o(rs1_a), .rs2_data_o(rs2_a), .rs1_busy_o(busy1_a), .rs2_busy_o(busy2_a)
  );

  reg_file_sb #(.DATA_W(8), .NUM_REGS(6), .ZERO_REG(1), .BYPASS(0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .ready_o(ready_b),
    .rd_wren_i(wren), .rd_addr_i(wa), .rd_be_i(be[0:0]), .rd_data_i(wd[7:0]),
    .sb_set_i(sb_set), .sb_addr_i(sa), .rs1_addr_i(r1), .rs2_addr_i(r2),
    .rs1_data_o(rs1_b), .rs2_data_o(rs2_b), .rs1_busy_o(busy1_b), .rs2_busy_o(busy2_b)
  );

  function automatic logic [31:0] merge32(logic [31:0] o, logic [31:0] n, logic [3:0] e);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = e[b] ? n[b*8 +: 8] : o[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_a_data(logic [2:0] a);
    if (ma_scrub != 0) return 32'h0;
    if (wren && !clear && wa == a) return merge32(ma[a], wd, be);
    return ma[a];
  endfunction

  function automatic bit exp_a_busy(logic [2:0] a);
    if (ma_scrub != 0) return 1'b0;
    if (wren && !clear && wa == a) return sb_set && (sa == a);
    return mab[a];
  endfunction

  function automatic logic [7:0] exp_b_data(logic [2:0] a);
    if (mb_scrub != 0 || a == 0 || a >= 6) return 8'h0;
    return mb[a];
  endfunction

  function automatic bit exp_b_busy(logic [2:0] a);
    if (mb_scrub != 0 || a == 0 || a >= 6) return 1'b0;
    return mbb[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin ma[i] = '0; mab[i] = 1'b0; end
    for (int i = 0; i < 6; i++) begin mb[i] = '0; mbb[i] = 1'b0; end
    ma_scrub = 8;
    mb_scrub = 6;
  endtask

  task automatic idle();
    clear = 0; wren = 0; sb_set = 0; wa = 0; sa = 0; be = 0; wd = 0; r1 = 0; r2 = 0;
  endtask

  // Advance the reference by one edge under the current inputs, then clock the DUTs.
  task automatic tick();
    if (ma_scrub > 0) ma_scrub--;
    else if (clear) begin
      for (int i = 0; i < 8; i++) begin ma[i] = '0; mab[i] = 1'b0; end
      ma_scrub = 8;
    end else begin
      if (wren) begin ma[wa] = merge32(ma[wa], wd, be); mab[wa] = 1'b0; end
      if (sb_set) mab[sa] = 1'b1;
    end
    if (mb_scrub > 0) mb_scrub--;
    else if (clear) begin
      for (int i = 0; i < 6; i++) begin mb[i] = '0; mbb[i] = 1'b0; end
      mb_scrub = 6;
    end else begin
      if (wren && wa != 0 && wa < 6) begin
        if (be[0]) mb[wa] = wd[7:0];
        mbb[wa] = 1'b0;
      end
      if (sb_set && sa != 0 && sa < 6) mbb[sa] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    if (ready_a !== 1'b0) begin errors++; $display("FAIL reset_ready_a got %b exp 0", ready_a); end
    checks++;
    rst_n = 1;
    for (int c = 1; c <= 10; c++) begin
      r1 = 3'($urandom);
      tick();
      if (ready_a !== (c >= 8)) begin errors++; $display("FAIL reset_ready_a cyc %0d got %b", c, ready_a); end
      checks++;
      if (ready_b !== (c >= 6)) begin errors++; $display("FAIL reset_ready_b cyc %0d got %b", c, ready_b); end
      checks++;
      if (rs1_a !== exp_a_data(r1)) begin errors++; $display("FAIL reset_scrub_rs1 cyc %0d got %h exp %h", c, rs1_a, exp_a_data(r1)); end
      checks++;
    end
    for (int i = 0; i < 8; i++) begin
      r1 = 3'(i);
      r2 = 3'(7 - i);
      #1;
      if (rs1_a !== 32'h0 || rs2_a !== 32'h0) begin errors++; $display("FAIL reset_read_a r%0d got %h %h exp 0", i, rs1_a, rs2_a); end
      checks++;
      if (rs1_b !== 8'h0 || busy1_a !== 1'b0) begin errors++; $display("FAIL reset_read_b r%0d got %h busy %b exp 0", i, rs1_b, busy1_a); end
      checks++;
    end
  endtask

  task automatic test_write_read();
    idle();
    wren = 1; wa = 3; be = 4'hF; wd = 32'h000000A5; r1 = 3;
    #1;
    if (rs1_a !== 32'hA5) begin errors++; $display("FAIL bypass_a got %h exp a5", rs1_a); end
    checks++;
    if (rs1_b !== 8'h00) begin errors++; $display("FAIL nobypass_b got %h exp 00", rs1_b); end
    checks++;
    tick();
    idle(); r1 = 3;
    #1;
    if (rs1_a !== 32'hA5) begin errors++; $display("FAIL read_a got %h exp a5", rs1_a); end
    checks++;
    if (rs1_b !== 8'hA5) begin errors++; $display("FAIL read_b got %h exp a5", rs1_b); end
    checks++;
  endtask

  task automatic test_byte_enable();
    idle();
    wren = 1; wa = 5; be = 4'hF; wd = 32'h11223344;
    tick();
    be = 4'b0010; wd = 32'hFFFFFFFF; r2 = 5;
    #1;
    if (rs2_a !== 32'h1122FF44) begin errors++; $display("FAIL be_bypass got %h exp 1122ff44", rs2_a); end
    checks++;
    tick();
    idle(); r2 = 5;
    #1;
    if (rs2_a !== 32'h1122FF44) begin errors++; $display("FAIL be_stored got %h exp 1122ff44", rs2_a); end
    checks++;
  endtask

  task automatic test_scoreboard();
    idle();
    sb_set = 1; sa = 2;
    tick();
    idle(); r1 = 2;
    #1;
    if (busy1_a !== 1'b1 || busy1_b !== 1'b1) begin errors++; $display("FAIL sb_set got %b %b exp 1 1", busy1_a, busy1_b); end
    checks++;
    wren = 1; wa = 2; be = 4'hF; wd = 32'h3C; sb_set = 1; sa = 2;
    #1;
    if (busy1_a !== 1'b1 || busy1_b !== 1'b1) begin errors++; $display("FAIL sb_set_wr_same got %b %b exp 1 1", busy1_a, busy1_b); end
    checks++;
    tick();
    idle(); r1 = 2;
    #1;
    if (busy1_a !== 1'b1 || busy1_b !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %b %b exp 1 1", busy1_a, busy1_b); end
    checks++;
    wren = 1; wa = 2; be = 4'h0; wd = 32'hFFFFFFFF;
    #1;
    if (busy1_a !== 1'b0 || busy1_b !== 1'b1) begin errors++; $display("FAIL sb_clr_same got %b %b exp 0 1", busy1_a, busy1_b); end
    checks++;
    tick();
    idle(); r1 = 2;
    #1;
    if (busy1_a !== 1'b0 || busy1_b !== 1'b0) begin errors++; $display("FAIL sb_clr got %b %b exp 0 0", busy1_a, busy1_b); end
    checks++;
    if (rs1_a !== 32'h3C || rs1_b !== 8'h3C) begin errors++; $display("FAIL sb_be0_keep got %h %h exp 3c", rs1_a, rs1_b); end
    checks++;
  endtask

  task automatic test_zero_reg();
    idle();
    wren = 1; wa = 0; be = 4'hF; wd = 32'h7F; sb_set = 1; sa = 0;
    tick();
    idle(); r1 = 0;
    #1;
    if (rs1_b !== 8'h0 || busy1_b !== 1'b0) begin errors++; $display("FAIL zero_reg_b got %h busy %b exp 0 0", rs1_b, busy1_b); end
    checks++;
    if (rs1_a !== 32'h7F || busy1_a !== 1'b1) begin errors++; $display("FAIL r0_a got %h busy %b exp 7f 1", rs1_a, busy1_a); end
    checks++;
    wren = 1; wa = 7; be = 4'hF; wd = 32'hC3; sb_set = 1; sa = 7;
    tick();
    idle(); r1 = 7;
    #1;
    if (rs1_b !== 8'h0 || busy1_b !== 1'b0) begin errors++; $display("FAIL oob_b got %h busy %b exp 0 0", rs1_b, busy1_b); end
    checks++;
    if (rs1_a !== 32'hC3 || busy1_a !== 1'b1) begin errors++; $display("FAIL r7_a got %h busy %b exp c3 1", rs1_a, busy1_a); end
    checks++;
  endtask

  task automatic test_clear();
    int first;
    idle();
    sb_set = 1; sa = 4;
    tick();
    clear = 1; wren = 1; wa = 1; be = 4'hF; wd = 32'h55; sb_set = 1; sa = 3;
    tick();
    idle();
    if (ready_a !== 1'b0 || ready_b !== 1'b0) begin errors++; $display("FAIL clear_enter got %b %b exp 0 0", ready_a, ready_b); end
    checks++;
    first = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (ready_a === 1'b1 && first < 0) first = c;
      if (ready_a !== (ma_scrub == 0)) begin errors++; $display("FAIL clear_ready_a cyc %0d got %b", c, ready_a); end
      checks++;
    end
    if (first != 8) begin errors++; $display("FAIL clear_scrub_len got %0d exp 8", first); end
    checks++;
    for (int i = 0; i < 8; i++) begin
      r1 = 3'(i);
      #1;
      if (rs1_a !== 32'h0 || busy1_a !== 1'b0) begin errors++; $display("FAIL clear_read_a r%0d got %h busy %b exp 0 0", i, rs1_a, busy1_a); end
      checks++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clear  = ($urandom_range(0, 63) == 0);
      wren   = 1'($urandom);
      wa     = 3'($urandom);
      be     = 4'($urandom);
      wd     = $urandom;
      sb_set = 1'($urandom);
      sa     = 3'($urandom);
      r1     = 3'($urandom);
      r2     = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom);
      #1;
      if (ready_a !== (ma_scrub == 0) || ready_b !== (mb_scrub == 0)) begin errors++; $display("FAIL rnd_ready cyc %0d got %b %b", i, ready_a, ready_b); end
      checks++;
      if (rs1_a !== exp_a_data(r1) || rs2_a !== exp_a_data(r2)) begin errors++; $display("FAIL rnd_data_a cyc %0d got %h %h exp %h %h", i, rs1_a, rs2_a, exp_a_data(r1), exp_a_data(r2)); end
      checks++;
      if (busy1_a !== exp_a_busy(r1) || busy2_a !== exp_a_busy(r2)) begin errors++; $display("FAIL rnd_busy_a cyc %0d got %b %b exp %b %b", i, busy1_a, busy2_a, exp_a_busy(r1), exp_a_busy(r2)); end
      checks++;
      if (rs1_b !== exp_b_data(r1) || rs2_b !== exp_b_data(r2)) begin errors++; $display("FAIL rnd_data_b cyc %0d got %h %h exp %h %h", i, rs1_b, rs2_b, exp_b_data(r1), exp_b_data(r2)); end
      checks++;
      if (busy1_b !== exp_b_busy(r1) || busy2_b !== exp_b_busy(r2)) begin errors++; $display("FAIL rnd_busy_b cyc %0d got %b %b exp %b %b", i, busy1_b, busy2_b, exp_b_busy(r1), exp_b_busy(r2)); end
      checks++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    idle();
    for (int c = 0; c < 10 && ma_scrub != 0; c++) tick();
    wren = 1; wa = 6; be = 4'hF; wd = 32'hDEADBEEF;
    tick();
    idle(); sb_set = 1; sa = 6;
    tick();
    idle(); r1 = 6;
    #2;
    rst_n = 0;
    #1;
    if (ready_a !== 1'b0 || rs1_a !== 32'h0 || busy1_a !== 1'b0) begin errors++; $display("FAIL midrst_a got %b %h %b exp 0 0 0", ready_a, rs1_a, busy1_a); end
    checks++;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (ready_a !== (c >= 8)) begin errors++; $display("FAIL midrst_ready cyc %0d got %b", c, ready_a); end
      checks++;
    end
    #1;
    if (rs1_a !== 32'h0 || busy1_a !== 1'b0 || rs1_b !== 8'h0 || busy1_b !== 1'b0) begin errors++; $display("FAIL midrst_read got %h %b %h %b exp 0", rs1_a, busy1_a, rs1_b, busy1_b); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_scoreboard();
    test_zero_reg();
    test_clear();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
